// File: rtl/alu_issue_stage.sv
// Issue stage in front of the 16-bit combinational ALU: request FIFO, ALU drive, result register.
// Optional accumulator operand path enabled by defining ALU_ISSUE_ACC_EN.
module alu_issue_stage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [WIDTH-1:0]         req_a,
    input  logic [WIDTH-1:0]         req_b,
    input  logic [3:0]               req_select,
    input  logic                     req_mode,
    input  logic                     req_cin,
    input  logic                     req_use_cflag,
`ifdef ALU_ISSUE_ACC_EN
    input  logic                     req_use_acc,
`endif
    output logic [WIDTH-1:0]         alu_in_a,
    output logic [WIDTH-1:0]         alu_in_b,
    output logic [3:0]               alu_select,
    output logic                     alu_mode,
    output logic                     alu_carry_in,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic                     alu_carry_out,
    input  logic                     alu_compare,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_carry,
    output logic                     rsp_compare,
    output logic                     rsp_zero,
    output logic                     flag_carry,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       select;
        logic             mode;
        logic             cin;
        logic             use_cflag;
`ifdef ALU_ISSUE_ACC_EN
        logic             use_acc;
`endif
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          in_entry;
    entry_t          head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            issue;
    logic            not_empty;

    assign not_empty = (fifo_count != '0);
    assign req_ready = !rst && (fifo_count != CW'(DEPTH));
    assign push      = req_valid && req_ready;
    assign issue     = not_empty && (!rsp_valid || rsp_ready);
    assign head      = mem[rd_ptr];

    always_comb begin
        in_entry           = '0;
        in_entry.a         = req_a;
        in_entry.b         = req_b;
        in_entry.select    = req_select;
        in_entry.mode      = req_mode;
        in_entry.cin       = req_cin;
        in_entry.use_cflag = req_use_cflag;
`ifdef ALU_ISSUE_ACC_EN
        in_entry.use_acc   = req_use_acc;
`endif
    end

    // Storage needs no reset: count and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_carry   <= 1'b0;
            rsp_compare <= 1'b0;
            rsp_zero    <= 1'b0;
            flag_carry  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, issue})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (issue) begin
                rsp_valid   <= 1'b1;
                rsp_data    <= alu_result;
                rsp_carry   <= alu_carry_out;
                rsp_compare <= alu_compare;
                rsp_zero    <= (alu_result == '0);
                flag_carry  <= alu_carry_out;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // Flag captured on the same edge as the result, so a chained op sees it at once.
    always_comb begin
        alu_in_a     = '0;
        alu_in_b     = '0;
        alu_select   = '0;
        alu_mode     = 1'b0;
        alu_carry_in = 1'b0;
        if (not_empty) begin
            alu_in_a     = head.a;
            alu_in_b     = head.b;
            alu_select   = head.select;
            alu_mode     = head.mode;
            alu_carry_in = head.use_cflag ? flag_carry : head.cin;
`ifdef ALU_ISSUE_ACC_EN
            if (head.use_acc) begin
                alu_in_a = rsp_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a behavioural ALU attached.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_select;
    logic        req_mode;
    logic        req_cin;
    logic        req_use_cflag;
    logic [15:0] alu_in_a;
    logic [15:0] alu_in_b;
    logic [3:0]  alu_select;
    logic        alu_mode;
    logic        alu_carry_in;
    logic [15:0] alu_result;
    logic        alu_carry_out;
    logic        alu_compare;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_carry;
    logic        rsp_compare;
    logic        rsp_zero;
    logic        flag_carry;
    logic [2:0]  fifo_count;

    int vectors = 0;
    int fails   = 0;

    typedef struct {
        logic [15:0] data;
        logic        carry;
        logic        compare;
        logic        zero;
    } exp_t;

    exp_t exp_q[$];
    logic model_carry = 1'b0;

    alu_issue_stage #(.WIDTH(16), .DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .req_select(req_select),
        .req_mode(req_mode),
        .req_cin(req_cin),
        .req_use_cflag(req_use_cflag),
`ifdef ALU_ISSUE_ACC_EN
        .req_use_acc(1'b0),
`endif
        .alu_in_a(alu_in_a),
        .alu_in_b(alu_in_b),
        .alu_select(alu_select),
        .alu_mode(alu_mode),
        .alu_carry_in(alu_carry_in),
        .alu_result(alu_result),
        .alu_carry_out(alu_carry_out),
        .alu_compare(alu_compare),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_carry(rsp_carry),
        .rsp_compare(rsp_compare),
        .rsp_zero(rsp_zero),
        .flag_carry(flag_carry),
        .fifo_count(fifo_count)
    );

    // Behavioural ALU: {carry_out, compare, result}
    function automatic logic [17:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] s, input logic m, input logic c);
        logic [16:0] t;
        logic [15:0] r;
        logic        co;
        if (!m) begin
            case (s)
                4'b1001: t = {1'b0, a} + {1'b0, b} + 17'(c);
                4'b0110: t = {1'b0, a} + {1'b0, ~b} + 17'(c);
                default: t = {1'b0, a} + 17'(c);
            endcase
            r  = t[15:0];
            co = t[16];
        end else begin
            case (s)
                4'b0110: r = a ^ b;
                4'b0101: r = ~b;
                4'b0011: r = 16'h0000;
                4'b1011: r = a & b;
                4'b1110: r = a | b;
                default: r = ~a;
            endcase
            co = r[15];
        end
        return {co, (a == b), r};
    endfunction

    assign {alu_carry_out, alu_compare, alu_result} =
        alu_f(alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: ops retire in acceptance order, so the carry chain follows push order.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_carry = 1'b0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_carry", 32'(rsp_carry), 32'(e.carry));
                    chk("rsp_compare", 32'(rsp_compare), 32'(e.compare));
                    chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
                    chk("flag_carry", 32'(flag_carry), 32'(e.carry));
                end
            end
            if (req_valid && req_ready) begin
                logic [17:0] r;
                exp_t e;
                r = alu_f(req_a, req_b, req_select, req_mode,
                          req_use_cflag ? model_carry : req_cin);
                e.data    = r[15:0];
                e.compare = r[16];
                e.carry   = r[17];
                e.zero    = (r[15:0] == 16'h0000);
                model_carry = e.carry;
                exp_q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                            input logic m, input logic c, input logic u);
        bit done;
        done          = 0;
        req_a         = a;
        req_b         = b;
        req_select    = s;
        req_mode      = m;
        req_cin       = c;
        req_use_cflag = u;
        req_valid     = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            if (req_ready) done = 1;
            step();
        end
        req_valid = 1'b0;
        if (!done) chk("push_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        bit done;
        done      = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (fifo_count == 0 && !rsp_valid) done = 1;
            else step();
        end
        if (!done) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    logic [3:0] sel_tab [6];

    initial begin
        sel_tab[0] = 4'b1001;
        sel_tab[1] = 4'b0110;
        sel_tab[2] = 4'b0101;
        sel_tab[3] = 4'b0011;
        sel_tab[4] = 4'b1011;
        sel_tab[5] = 4'b1110;
        rst = 1'b1;
        req_valid = 1'b0;
        req_a = '0;
        req_b = '0;
        req_select = '0;
        req_mode = 1'b0;
        req_cin = 1'b0;
        req_use_cflag = 1'b0;
        rsp_ready = 1'b0;
        step();
        step();
        chk("ready_in_reset", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(req_ready), 32'd1);
        chk("count_reset", 32'(fifo_count), 32'd0);
        chk("valid_reset", 32'(rsp_valid), 32'd0);
        chk("data_reset", 32'(rsp_data), 32'd0);
        chk("flag_reset", 32'(flag_carry), 32'd0);
        chk("alu_a_empty", 32'(alu_in_a), 32'd0);
        step();

        // single add, latency
        rsp_ready = 1'b1;
        push_req(16'h1234, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b0);
        chk("lat_count", 32'(fifo_count), 32'd1);
        chk("lat_valid_early", 32'(rsp_valid), 32'd0);
        step();
        chk("lat_valid", 32'(rsp_valid), 32'd1);
        chk("lat_data", 32'(rsp_data), 32'h1235);
        chk("lat_zero", 32'(rsp_zero), 32'd0);
        step();
        chk("lat_consumed", 32'(rsp_valid), 32'd0);

        push_req(16'h00FF, 16'h0F0F, 4'b0110, 1'b1, 1'b0, 1'b0);
        drain();

        // carry chaining
        rsp_ready = 1'b0;
        push_req(16'hFFFF, 16'h0000, 4'b0101, 1'b1, 1'b0, 1'b0);
        push_req(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b1);
        chk("chain_rsp_carry", 32'(rsp_carry), 32'd1);
        chk("chain_flag", 32'(flag_carry), 32'd1);
        chk("chain_alu_cin", 32'(alu_carry_in), 32'd1);
        chk("chain_alu_a", 32'(alu_in_a), 32'h0001);
        drain();

        // backpressure and full
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push_req(16'(16'h0100 * i), 16'(i), 4'b1001, 1'b0, 1'b0, 1'b0);
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_ready", 32'(req_ready), 32'd0);
        chk("full_held", 32'(rsp_valid), 32'd1);
        step();
        chk("full_hold_data", 32'(rsp_data), 32'h0000);
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stream_valid", 32'(rsp_valid), 32'd1);
            step();
        end
        chk("stream_done", 32'(rsp_valid), 32'd0);
        chk("stream_count", 32'(fifo_count), 32'd0);

        // reset mid-operation
        rsp_ready = 1'b0;
        push_req(16'hFFFF, 16'h0000, 4'b0101, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            push_req(16'h0003, 16'h0004, 4'b1001, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_count", 32'(fifo_count), 32'd3);
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        chk("pre_rst_flag", 32'(flag_carry), 32'd1);
        rst = 1'b1;
        step();
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_flag", 32'(flag_carry), 32'd0);
        chk("rst_data", 32'(rsp_data), 32'd0);
        chk("rst_alu", {alu_in_a, alu_in_b}, 32'd0);
        chk("rst_alu_ctl", 32'({alu_select, alu_mode, alu_carry_in}), 32'd0);
        rst = 1'b0;
        step();

        // compare and zero
        rsp_ready = 1'b1;
        push_req(16'h0000, 16'h0000, 4'b0011, 1'b1, 1'b0, 1'b0);
        drain();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            req_valid     = ($urandom_range(0, 3) != 0);
            req_a         = 16'($urandom);
            req_b         = ($urandom_range(0, 7) == 0) ? req_a : 16'($urandom);
            req_select    = sel_tab[$urandom_range(0, 5)];
            req_mode      = 1'($urandom_range(0, 1));
            req_cin       = 1'($urandom_range(0, 1));
            req_use_cflag = 1'($urandom_range(0, 1));
            rsp_ready     = ($urandom_range(0, 2) != 0);
            step();
        end
        req_valid = 1'b0;
        drain();
        step();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
        $fatal(1);
    end

endmodule
